// File: rtl/obi_dma_pkg.sv
// Shared types and constants for the OBI word-DMA initiator.
//   dma_state_e : initiator FSM states
//   dma_mode_e  : copy (read src, write dst) or fill (write constant to dst)
//   OBI_BE_WORD : byte enables for a full-word access
package obi_dma_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdWait,
    StWrReq,
    StWrWait,
    StDone
  } dma_state_e;

  typedef enum logic {
    DMA_COPY = 1'b0,
    DMA_FILL = 1'b1
  } dma_mode_e;

  localparam logic [3:0] OBI_BE_WORD = 4'hF;

endpackage

// File: rtl/obi_dma_initiator_if.sv
// OBI data-bus signals between the DMA initiator and a memory responder.
//   master : initiator side (drives req/addr/we/be/wdata, receives gnt/rvalid/rdata)
//   slave  : responder side
interface obi_dma_initiator_if;

  logic        data_req_o;
  logic        data_gnt_i;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;

  modport master (
    output data_req_o,
    output data_addr_o,
    output data_we_o,
    output data_be_o,
    output data_wdata_o,
    input  data_gnt_i,
    input  data_rvalid_i,
    input  data_rdata_i
  );

  modport slave (
    input  data_req_o,
    input  data_addr_o,
    input  data_we_o,
    input  data_be_o,
    input  data_wdata_o,
    output data_gnt_i,
    output data_rvalid_i,
    output data_rdata_i
  );

endinterface

// File: rtl/obi_dma_fifo.sv
// Synchronous FIFO holding one burst of read data between the read and write phases.
//   clk, rst        : clock, asynchronous active-high reset (empties the FIFO)
//   push, push_data : write one word
//   pop             : discard the head word
//   head            : oldest word (valid when !empty)
//   empty, full     : occupancy flags
module obi_dma_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // Extra MSB on the pointers distinguishes full from empty.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/obi_dma_initiator.sv
// OBI word-DMA initiator: copies len words from src to dst, or fills dst with a constant,
// in bursts of at most FIFO_DEPTH words (all reads of a burst, then all its writes).
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   start_i                 : command strobe, honoured only when idle
//   mode_i                  : 0 copy, 1 fill
//   src_addr_i, dst_addr_i  : byte addresses, forced word aligned
//   len_i                   : word count (0 completes without bus traffic)
//   fill_value_i            : write data in fill mode
//   busy_o, done_o          : command in progress, one-cycle completion pulse
//   bus                     : OBI data-bus initiator port
module obi_dma_initiator
  import obi_dma_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LEN_W      = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 mode_i,
  input  logic [31:0]          src_addr_i,
  input  logic [31:0]          dst_addr_i,
  input  logic [LEN_W-1:0]     len_i,
  input  logic [31:0]          fill_value_i,
  output logic                 busy_o,
  output logic                 done_o,
  obi_dma_initiator_if.master  bus
);

  localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  function automatic logic [CW-1:0] calc_burst(input logic [LEN_W-1:0] rem);
    if (rem >= LEN_W'(FIFO_DEPTH)) return CW'(FIFO_DEPTH);
    return rem[CW-1:0];
  endfunction

  dma_state_e       state_q, state_d;
  dma_mode_e        mode_q, mode_d;
  logic [31:0]      src_q, src_d, dst_q, dst_d, fill_q, fill_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [CW-1:0]    burst_q, burst_d, issued_q, issued_d;
  logic [CW-1:0]    rd_rcv_q, rd_rcv_d, wr_rcv_q, wr_rcv_d;

  logic        req, we, push, pop, done;
  logic [31:0] addr, wdata, fifo_head;
  logic        fifo_empty, fifo_full;

  obi_dma_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push),
    .push_data (bus.data_rdata_i),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    src_d       = src_q;
    dst_d       = dst_q;
    fill_d      = fill_q;
    remaining_d = remaining_q;
    burst_d     = burst_q;
    issued_d    = issued_q;
    rd_rcv_d    = rd_rcv_q;
    wr_rcv_d    = wr_rcv_q;
    req         = 1'b0;
    we          = 1'b0;
    addr        = '0;
    wdata       = '0;
    push        = 1'b0;
    pop         = 1'b0;
    done        = 1'b0;

    // Responses belong to the phase that issued them; outside these states they are stale.
    if (bus.data_rvalid_i && (state_q == StRdReq || state_q == StRdWait)) begin
      push     = !fifo_full;
      rd_rcv_d = rd_rcv_q + CW'(1);
    end
    if (bus.data_rvalid_i && (state_q == StWrReq || state_q == StWrWait)) begin
      wr_rcv_d = wr_rcv_q + CW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          mode_d      = dma_mode_e'(mode_i);
          src_d       = src_addr_i & WORD_MASK;
          dst_d       = dst_addr_i & WORD_MASK;
          fill_d      = fill_value_i;
          remaining_d = len_i;
          burst_d     = calc_burst(len_i);
          issued_d    = '0;
          rd_rcv_d    = '0;
          wr_rcv_d    = '0;
          if (len_i == '0)                          state_d = StDone;
          else if (dma_mode_e'(mode_i) == DMA_FILL) state_d = StWrReq;
          else                                      state_d = StRdReq;
        end
      end
      StRdReq: begin
        req  = 1'b1;
        addr = src_q;
        if (bus.data_gnt_i) begin
          src_d = src_q + 32'd4;
          if (issued_q + CW'(1) == burst_q) begin
            issued_d = '0;
            state_d  = StRdWait;
          end else begin
            issued_d = issued_q + CW'(1);
          end
        end
      end
      StRdWait: begin
        if (rd_rcv_q == burst_q) begin
          rd_rcv_d = '0;
          state_d  = StWrReq;
        end
      end
      StWrReq: begin
        req   = 1'b1;
        we    = 1'b1;
        addr  = dst_q;
        wdata = (mode_q == DMA_COPY) ? fifo_head : fill_q;
        if (bus.data_gnt_i) begin
          pop         = (mode_q == DMA_COPY) && !fifo_empty;
          dst_d       = dst_q + 32'd4;
          remaining_d = remaining_q - LEN_W'(1);
          if (issued_q + CW'(1) == burst_q) begin
            issued_d = '0;
            state_d  = StWrWait;
          end else begin
            issued_d = issued_q + CW'(1);
          end
        end
      end
      StWrWait: begin
        if (wr_rcv_q == burst_q) begin
          wr_rcv_d = '0;
          if (remaining_q == '0) begin
            state_d = StDone;
          end else begin
            burst_d = calc_burst(remaining_q);
            state_d = (mode_q == DMA_COPY) ? StRdReq : StWrReq;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      mode_q      <= DMA_COPY;
      src_q       <= '0;
      dst_q       <= '0;
      fill_q      <= '0;
      remaining_q <= '0;
      burst_q     <= '0;
      issued_q    <= '0;
      rd_rcv_q    <= '0;
      wr_rcv_q    <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      fill_q      <= fill_d;
      remaining_q <= remaining_d;
      burst_q     <= burst_d;
      issued_q    <= issued_d;
      rd_rcv_q    <= rd_rcv_d;
      wr_rcv_q    <= wr_rcv_d;
    end
  end

  assign bus.data_req_o   = req;
  assign bus.data_addr_o  = addr;
  assign bus.data_we_o    = we;
  assign bus.data_be_o    = req ? OBI_BE_WORD : 4'h0;
  assign bus.data_wdata_o = wdata;
  assign busy_o           = (state_q != StIdle);
  assign done_o           = done;

endmodule
